// File: rtl/speed_push_counter.sv
// speed_push_counter
//   Counts accepted left/right button presses during a speed round, then
//   compares the totals on the end-of-round pulse and holds the result for
//   the LED countdown controller until the next round starts.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   speed_round  : level; its rising edge starts a round
//   winspeed     : one-cycle end-of-round pulse
//   speed_exit   : round display finished, return to idle
//   left_btn     : raw asynchronous left button
//   right_btn    : raw asynchronous right button
//   speed_right  : right total > left total (registered at winspeed)
//   speed_tie    : right total == left total (registered at winspeed)
//   left_count   : left accepted-press total (saturating)
//   right_count  : right accepted-press total (saturating)
//   counting     : high while a round is being counted
module speed_push_counter #(
    parameter int unsigned CW      = 8,
    parameter int unsigned LOCKOUT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          speed_round,
    input  logic          winspeed,
    input  logic          speed_exit,
    input  logic          left_btn,
    input  logic          right_btn,
    output logic          speed_right,
    output logic          speed_tie,
    output logic [CW-1:0] left_count,
    output logic [CW-1:0] right_count,
    output logic          counting
);

    localparam int unsigned   LW        = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Synchronizer chains: bit 0 = first flop, bit 2 = third flop.
    logic [2:0]    l_sync_q, r_sync_q;
    logic [LW-1:0] l_lock_q, l_lock_d;
    logic [LW-1:0] r_lock_q, r_lock_d;
    logic          speed_round_q;
    logic [CW-1:0] l_cnt_q, l_cnt_d;
    logic [CW-1:0] r_cnt_q, r_cnt_d;
    logic          right_q, right_d;
    logic          tie_q, tie_d;

    logic l_edge, r_edge, l_acc, r_acc, start;

    assign l_edge = l_sync_q[1] & ~l_sync_q[2];
    assign r_edge = r_sync_q[1] & ~r_sync_q[2];
    assign l_acc  = l_edge & (l_lock_q == '0) & (state_q == COUNT);
    assign r_acc  = r_edge & (r_lock_q == '0) & (state_q == COUNT);
    assign start  = speed_round & ~speed_round_q;

    // Lockout: reload on an accepted press, otherwise drain toward zero.
    always_comb begin
        l_lock_d = l_lock_q;
        r_lock_d = r_lock_q;
        if (l_acc) begin
            l_lock_d = LOCK_LOAD;
        end else if (l_lock_q != '0) begin
            l_lock_d = l_lock_q - LW'(1);
        end
        if (r_acc) begin
            r_lock_d = LOCK_LOAD;
        end else if (r_lock_q != '0) begin
            r_lock_d = r_lock_q - LW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        l_cnt_d = l_cnt_q;
        r_cnt_d = r_cnt_q;
        right_d = right_q;
        tie_d   = tie_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    l_cnt_d = '0;
                    r_cnt_d = '0;
                    right_d = 1'b0;
                    tie_d   = 1'b0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                // Results use the pre-increment totals; a press accepted in
                // the winspeed cycle is deliberately dropped.
                if (winspeed) begin
                    right_d = (r_cnt_q > l_cnt_q);
                    tie_d   = (r_cnt_q == l_cnt_q);
                    state_d = HOLD;
                end else begin
                    if (l_acc && (l_cnt_q != CNT_MAX)) begin
                        l_cnt_d = l_cnt_q + CW'(1);
                    end
                    if (r_acc && (r_cnt_q != CNT_MAX)) begin
                        r_cnt_d = r_cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (speed_exit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_sync_q      <= '0;
            r_sync_q      <= '0;
            l_lock_q      <= '0;
            r_lock_q      <= '0;
            speed_round_q <= 1'b0;
            l_cnt_q       <= '0;
            r_cnt_q       <= '0;
            right_q       <= 1'b0;
            tie_q         <= 1'b0;
        end else begin
            l_sync_q      <= {l_sync_q[1:0], left_btn};
            r_sync_q      <= {r_sync_q[1:0], right_btn};
            l_lock_q      <= l_lock_d;
            r_lock_q      <= r_lock_d;
            speed_round_q <= speed_round;
            l_cnt_q       <= l_cnt_d;
            r_cnt_q       <= r_cnt_d;
            right_q       <= right_d;
            tie_q         <= tie_d;
        end
    end

    assign speed_right = right_q;
    assign speed_tie   = tie_q;
    assign left_count  = l_cnt_q;
    assign right_count = r_cnt_q;
    assign counting    = (state_q == COUNT);

endmodule

// File: tb/tb_speed_push_counter.sv
// Directed bench for speed_push_counter. Three instances share one stimulus:
// the default build (CW=8, LOCKOUT=4), a no-lockout build and a 3-bit
// counter build, so bounce and saturation behaviour are checked side by side.
module tb_speed_push_counter;

    logic clk = 1'b0;
    logic rst, speed_round, winspeed, speed_exit, left_btn, right_btn;

    logic       a_right, a_tie, a_counting;
    logic [7:0] a_left_cnt, a_right_cnt;
    logic       n_right, n_tie, n_counting;
    logic [7:0] n_left_cnt, n_right_cnt;
    logic       s_right, s_tie, s_counting;
    logic [2:0] s_left_cnt, s_right_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    speed_push_counter #(.CW(8), .LOCKOUT(4)) u_dut (
        .clk(clk), .rst(rst), .speed_round(speed_round), .winspeed(winspeed),
        .speed_exit(speed_exit), .left_btn(left_btn), .right_btn(right_btn),
        .speed_right(a_right), .speed_tie(a_tie), .left_count(a_left_cnt),
        .right_count(a_right_cnt), .counting(a_counting)
    );

    speed_push_counter #(.CW(8), .LOCKOUT(0)) u_nolock (
        .clk(clk), .rst(rst), .speed_round(speed_round), .winspeed(winspeed),
        .speed_exit(speed_exit), .left_btn(left_btn), .right_btn(right_btn),
        .speed_right(n_right), .speed_tie(n_tie), .left_count(n_left_cnt),
        .right_count(n_right_cnt), .counting(n_counting)
    );

    speed_push_counter #(.CW(3), .LOCKOUT(4)) u_sat (
        .clk(clk), .rst(rst), .speed_round(speed_round), .winspeed(winspeed),
        .speed_exit(speed_exit), .left_btn(left_btn), .right_btn(right_btn),
        .speed_right(s_right), .speed_tie(s_tie), .left_count(s_left_cnt),
        .right_count(s_right_cnt), .counting(s_counting)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle press on the selected buttons, then a gap well past lockout.
    task automatic press(input logic l, input logic r);
        left_btn  = l;
        right_btn = r;
        tick();
        left_btn  = 1'b0;
        right_btn = 1'b0;
        repeat (7) tick();
    endtask

    task automatic new_round();
        speed_round = 1'b0;
        tick();
        speed_round = 1'b1;
        tick();
    endtask

    task automatic end_round();
        winspeed = 1'b1;
        tick();
        winspeed = 1'b0;
    endtask

    task automatic exit_round();
        speed_exit = 1'b1;
        tick();
        speed_exit = 1'b0;
    endtask

    initial begin
        rst = 1'b1; speed_round = 1'b0; winspeed = 1'b0; speed_exit = 1'b0;
        left_btn = 1'b0; right_btn = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check_eq("rst_left",     a_left_cnt,  0);
        check_eq("rst_right",    a_right_cnt, 0);
        check_eq("rst_counting", a_counting,  0);
        check_eq("rst_results",  {a_right, a_tie}, 0);

        // Presses in IDLE are ignored.
        repeat (5) press(1'b1, 1'b0);
        check_eq("idle_left",     a_left_cnt, 0);
        check_eq("idle_counting", a_counting, 0);

        // Right wins 7 to 3; first press also checks two-edge latency.
        speed_round = 1'b1;
        tick();
        check_eq("start_counting", a_counting, 1);
        left_btn = 1'b1;
        tick();
        left_btn = 1'b0;
        tick();
        check_eq("lat_n1", a_left_cnt, 0);
        tick();
        check_eq("lat_n2", a_left_cnt, 1);
        repeat (6) tick();
        repeat (2) press(1'b1, 1'b0);
        repeat (7) press(1'b0, 1'b1);
        end_round();
        check_eq("rw_left",      a_left_cnt,  3);
        check_eq("rw_right",     a_right_cnt, 7);
        check_eq("rw_speed_r",   a_right,     1);
        check_eq("rw_tie",       a_tie,       0);
        check_eq("rw_hold",      a_counting,  0);
        check_eq("rw_sat_right", s_right_cnt, 7);
        // HOLD ignores presses and winspeed.
        press(1'b1, 1'b0);
        end_round();
        check_eq("hold_left",  a_left_cnt, 3);
        check_eq("hold_res",   {a_right, a_tie}, 2);
        exit_round();
        tick();
        check_eq("exit_idle",  a_counting, 0);
        check_eq("exit_res",   {a_right, a_tie}, 2);
        check_eq("exit_right", a_right_cnt, 7);

        // speed_round held high does not retrigger.
        repeat (4) tick();
        check_eq("no_retrig", a_counting, 0);
        new_round();
        check_eq("restart_cnt",   a_counting, 1);
        check_eq("restart_left",  a_left_cnt, 0);
        check_eq("restart_right", a_right_cnt, 0);
        check_eq("restart_res",   {a_right, a_tie}, 0);

        // Tie with simultaneous presses.
        repeat (4) press(1'b1, 1'b1);
        end_round();
        check_eq("tie_left",  a_left_cnt,  4);
        check_eq("tie_right", a_right_cnt, 4);
        check_eq("tie_tie",   a_tie,       1);
        check_eq("tie_sr",    a_right,     0);
        exit_round();

        // Bounce: toggling right button for 6 cycles.
        new_round();
        for (int i = 0; i < 6; i++) begin
            right_btn = (i % 2 == 0);
            tick();
        end
        right_btn = 1'b0;
        repeat (8) tick();
        check_eq("bounce_lock",   a_right_cnt, 1);
        check_eq("bounce_nolock", n_right_cnt, 3);
        // Press whose edge lands in the winspeed cycle is dropped.
        right_btn = 1'b1;
        tick();
        right_btn = 1'b0;
        tick();
        end_round();
        check_eq("ws_drop_lock",   a_right_cnt, 1);
        check_eq("ws_drop_nolock", n_right_cnt, 3);
        check_eq("ws_drop_res",    {a_right, a_tie}, 2);
        exit_round();

        // Saturation on the 3-bit build.
        new_round();
        repeat (10) press(1'b1, 1'b0);
        check_eq("sat_left",  s_left_cnt, 7);
        check_eq("wide_left", a_left_cnt, 10);
        end_round();
        check_eq("sat_res",   {s_right, s_tie}, 0);
        check_eq("sat_right", s_right_cnt, 0);
        exit_round();

        // Mid-round reset.
        new_round();
        repeat (2) press(1'b1, 1'b1);
        check_eq("pre_rst_left", a_left_cnt, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_left",  a_left_cnt,  0);
        check_eq("mid_rst_right", a_right_cnt, 0);
        check_eq("mid_rst_cnt",   a_counting,  0);
        check_eq("mid_rst_res",   {a_right, a_tie}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/speed_push_counter.md
Name: speed_push_counter

Overview:
- Upstream neighbour of the speed-round LED countdown controller.
- Counts accepted left and right button presses between the start of a speed round and the end-of-round pulse `winspeed`.
- Compares the two totals and presents `speed_right` / `speed_tie` to the controller for its win display.
- Holds those results stable until the next round starts.

Parameters:
- CW, 8, width of each press counter; counters saturate at 2^CW-1.
- LOCKOUT, 4, clock cycles after an accepted press during which further edges on the same button are ignored (bounce rejection); 0 disables lockout.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- speed_round  in  1  level from main controller; its rising edge starts a round
- winspeed  in  1  one-cycle end-of-round pulse from the countdown controller
- speed_exit  in  1  level from the countdown controller; round display finished
- left_btn  in  1  raw asynchronous left player button
- right_btn  in  1  raw asynchronous right player button
- speed_right  out  1  right total > left total
- speed_tie  out  1  right total == left total
- left_count  out  CW  left accepted-press total
- right_count  out  CW  right accepted-press total
- counting  out  1  high while in COUNT

Behaviour:
- Clock and reset (already decided): single clock `clk`; reset `rst` is synchronous, active-high.
- Reset values:
  - State IDLE.
  - All outputs 0.
  - Synchronizer, edge and lockout registers 0.
  - `speed_round` previous-value register 0.
- Input path, per button, independent:
  - Three flops s1→s2→s3; `edge = s2 & ~s3`.
  - Accept = `edge & (lockout_cnt == 0) & (state == COUNT)`.
  - On accept, lockout_cnt loads LOCKOUT; otherwise it decrements toward 0.
  - Latency: a button rising before clock edge N is counted at edge N+2, so the count is visible after edge N+2.
- Round start detect: `start = speed_round & ~speed_round_d`, where `speed_round_d` is the registered previous value.
- IDLE:
  - Presses not counted.
  - `winspeed` and `speed_exit` ignored.
  - On `start`: clear both counts, `speed_right` and `speed_tie` to 0; next state COUNT.
- COUNT (`counting` = 1):
  - Each accept increments its counter by 1; hold at 2^CW-1, no wrap.
  - Simultaneous left and right accepts both count.
  - On `winspeed`:
    - Results register at that edge: `speed_right = (right_count > left_count)`, `speed_tie = (right_count == left_count)`, mutually exclusive.
    - Comparison uses counts *before* that cycle's increment; a press accepted in the `winspeed` cycle is dropped.
    - Next state HOLD.
  - `start` during COUNT is ignored.
- HOLD:
  - Counts and results frozen.
  - `speed_exit` high → IDLE; results and counts remain valid in IDLE until the next `start`.
  - `winspeed` and `start` are ignored in HOLD.
- `speed_round` held high continuously does not retrigger; only a fresh rising edge starts a round.
- Unused state encodings go to IDLE on the next clock.
- Reset asserted mid-round: the next edge returns all state and outputs to reset values; lockout counters are cleared.

Test Plan:
- Reset then idle presses: `rst` for 2 cycles, pulse `left_btn` 5 times in IDLE → `left_count` = 0, `right_count` = 0, `counting` = 0, results 0.
- Right wins: `speed_round` rises; 3 clean left presses and 7 right presses spaced ≥ LOCKOUT+3 cycles apart; then `winspeed` → next cycle `right_count` = 7, `left_count` = 3, `speed_right` = 1, `speed_tie` = 0, state HOLD; `speed_exit` → IDLE with results still 1/0.
- Tie and simultaneity: 4 presses with both buttons rising in the same cycle, then `winspeed` → both counts = 4, `speed_tie` = 1, `speed_right` = 0.
- Bounce/lockout (LOCKOUT = 4): `right_btn` toggles 0/1 every cycle for 6 cycles → `right_count` = 1 (LOCKOUT = 0 in a second run → 3); press landing in the `winspeed` cycle is not counted.
- Saturation (CW = 3): 10 left presses → `left_count` = 7, no wrap; 0 right presses; `winspeed` → `speed_right` = 0, `speed_tie` = 0 (left wins).
- Restart and mid-round reset: `speed_round` held high through HOLD→IDLE, no new COUNT; drop and raise it → counts and results clear, COUNT entered. Assert `rst` with counts nonzero → all outputs 0 after that edge.
